// File: rtl/bjx1_fetch_pkg.sv
// Shared fetch definitions: tile status codes, fetch FSM states and the
// instruction-length rule used by the fetch sequencer.
package bjx1_fetch_pkg;

  localparam logic [1:0] UMEM_OK_READY = 2'd0;
  localparam logic [1:0] UMEM_OK_OK    = 2'd1;
  localparam logic [1:0] UMEM_OK_HOLD  = 2'd2;
  localparam logic [1:0] UMEM_OK_FAULT = 2'd3;

  localparam logic [7:0] OP_PFX_WIDE_A = 8'h8A;
  localparam logic [7:0] OP_PFX_WIDE_B = 8'h8E;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  // The two wide prefixes differ only in bit 2, so one masked compare covers both.
  function automatic logic op_is32(input logic [15:0] word0);
    logic [7:0] wideMask;
    wideMask = ~(OP_PFX_WIDE_A ^ OP_PFX_WIDE_B);
    return (word0 & {wideMask, 8'h00}) == {OP_PFX_WIDE_A & wideMask, 8'h00};
  endfunction

endpackage

// File: rtl/if_len_decode.sv
// Combinational instruction-length decode: first halfword of the window in,
// width flag and PC increment out.
module if_len_decode
  import bjx1_fetch_pkg::*;
(
  input  logic [15:0] word0,
  output logic        is32,
  output logic [31:0] pcIncr
);

  assign is32   = op_is32(word0);
  assign pcIncr = is32 ? 32'd4 : 32'd2;

endmodule

// File: rtl/if_fetch_seq.sv
// Fetch sequencer: owns the fetch PC, consumes I-cache tile windows and hands
// one 16/32-bit instruction per cycle to decode, with redirect and fault handling.
module if_fetch_seq
  import bjx1_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hA000_0000
) (
  input  logic         clock,
  input  logic         reset,
  output logic [31:0]  icPcAddr,
  input  logic [47:0]  icPcVal,
  input  logic [1:0]   icPcOK,
  output logic [31:0]  idOpWord,
  output logic [31:0]  idOpPc,
  output logic         idOpLen,
  output logic         idOpValid,
  input  logic         idStall,
  input  logic         brValid,
  input  logic [31:0]  brPc,
  output logic         ifFault,
  output logic [31:0]  ifFaultPc,
  output fetch_state_t dbgState
);

  // Decode handshake: an op moves on every edge where idOpValid && !idStall;
  // while idStall is high the op register is frozen, except that a redirect
  // (brValid) always flushes it.
  localparam logic [31:0] RESET_PC_EVEN = {RESET_PC[31:1], 1'b0};

  fetch_state_t state, stateNext;
  logic [31:0]  pc, pcNext;
  logic [31:0]  opWordNext, opPcNext, faultPcNext;
  logic         opLenNext, opValidNext, faultNext;
  logic         is32;
  logic [31:0]  pcIncr;
  logic         decodeBusy;
  logic         unusedWinBits;

  // Only the first 32 bits of the window can belong to the current op.
  assign unusedWinBits = ^{icPcVal[47:32], brPc[0]};

  if_len_decode u_len (
    .word0  (icPcVal[15:0]),
    .is32   (is32),
    .pcIncr (pcIncr)
  );

  assign icPcAddr   = pc;
  assign dbgState   = state;
  assign decodeBusy = idOpValid && idStall;

  always_comb begin
    stateNext   = state;
    pcNext      = pc;
    opWordNext  = idOpWord;
    opPcNext    = idOpPc;
    opLenNext   = idOpLen;
    opValidNext = idOpValid;
    faultNext   = ifFault;
    faultPcNext = ifFaultPc;
    if (brValid) begin
      pcNext      = {brPc[31:1], 1'b0};
      opValidNext = 1'b0;
      faultNext   = 1'b0;
      stateNext   = ST_RUN;
    end else begin
      case (state)
        ST_RUN, ST_WAIT: begin
          if (icPcOK == UMEM_OK_FAULT) begin
            faultPcNext = pc;
            faultNext   = 1'b1;
            stateNext   = ST_FAULT;
            if (!idStall) opValidNext = 1'b0;
          end else if (icPcOK == UMEM_OK_OK && !decodeBusy) begin
            opWordNext  = is32 ? icPcVal[31:0] : {16'h0000, icPcVal[15:0]};
            opPcNext    = pc;
            opLenNext   = is32;
            opValidNext = 1'b1;
            pcNext      = pc + pcIncr;
            stateNext   = ST_RUN;
          end else begin
            if (icPcOK == UMEM_OK_READY || icPcOK == UMEM_OK_HOLD) stateNext = ST_WAIT;
            if (!idStall) opValidNext = 1'b0;
          end
        end
        ST_FAULT: begin
          if (!idStall) opValidNext = 1'b0;
        end
        default: stateNext = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_RUN;
      pc        <= RESET_PC_EVEN;
      idOpWord  <= 32'h0;
      idOpPc    <= 32'h0;
      idOpLen   <= 1'b0;
      idOpValid <= 1'b0;
      ifFault   <= 1'b0;
      ifFaultPc <= 32'h0;
    end else begin
      state     <= stateNext;
      pc        <= pcNext;
      idOpWord  <= opWordNext;
      idOpPc    <= opPcNext;
      idOpLen   <= opLenNext;
      idOpValid <= opValidNext;
      ifFault   <= faultNext;
      ifFaultPc <= faultPcNext;
    end
  end

endmodule

// File: tb/tb_if_fetch_seq.sv
// Bench for if_fetch_seq: reset/length vectors, directed miss/stall/redirect/
// fault sequences, and a random run against an instruction-stream model.
module tb_if_fetch_seq;
  import bjx1_fetch_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic [31:0]  icPcAddr;
  logic [47:0]  icPcVal;
  logic [1:0]   icPcOK;
  logic [31:0]  idOpWord, idOpPc;
  logic         idOpLen, idOpValid, idStall;
  logic         brValid;
  logic [31:0]  brPc;
  logic         ifFault;
  logic [31:0]  ifFaultPc;
  fetch_state_t dbgState;

  int checks = 0;
  int errors = 0;
  logic        useMem;
  logic [47:0] fixedWin;

  typedef struct {
    logic [47:0] win;
    logic [31:0] expWord;
    logic        expLen;
  } vec_t;
  vec_t tbl[8];

  if_fetch_seq dut (
    .clock(clock), .reset(reset), .icPcAddr(icPcAddr), .icPcVal(icPcVal),
    .icPcOK(icPcOK), .idOpWord(idOpWord), .idOpPc(idOpPc), .idOpLen(idOpLen),
    .idOpValid(idOpValid), .idStall(idStall), .brValid(brValid), .brPc(brPc),
    .ifFault(ifFault), .ifFaultPc(ifFaultPc), .dbgState(dbgState)
  );

  always #5 clock = ~clock;

  // Program image: a deterministic halfword per address, with some wide prefixes.
  function automatic logic [15:0] memw(input logic [31:0] a);
    logic [15:0] h;
    h = (a[16:1] * 16'h9E37) ^ a[31:16];
    if (h[1:0] == 2'b00) h[15:8] = 8'h8A;
    else if (h[3:0] == 4'h5) h[15:8] = 8'h8E;
    return h;
  endfunction

  always_comb
    icPcVal = useMem ? {memw(icPcAddr + 32'd4), memw(icPcAddr + 32'd2), memw(icPcAddr)} : fixedWin;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] a, p, w, expPc, expWord;
    logic [15:0] w0, w1;
    logic        expLen, live, preValid, preStall, preBr, preLen;
    logic [31:0] preBrPc, preAddr, preOpPc, preWord;
    logic [1:0]  preOk;
    int          r, transfers;

    tbl[0] = '{48'h0009_1234_8A00, 32'h1234_8A00, 1'b1};
    tbl[1] = '{48'h0009_0009_0009, 32'h0000_0009, 1'b0};
    tbl[2] = '{48'h5555_ABCD_8E7F, 32'hABCD_8E7F, 1'b1};
    tbl[3] = '{48'h0000_FFFF_8B00, 32'h0000_8B00, 1'b0};
    tbl[4] = '{48'h1111_2222_0A8A, 32'h0000_0A8A, 1'b0};
    tbl[5] = '{48'h0000_C3C3_8AFF, 32'hC3C3_8AFF, 1'b1};
    tbl[6] = '{48'h0000_1111_8C00, 32'h0000_8C00, 1'b0};
    tbl[7] = '{48'h0000_1111_CE00, 32'h0000_CE00, 1'b0};

    // Reset, with a redirect pending to show reset wins.
    reset = 1'b1; icPcOK = UMEM_OK_OK; idStall = 1'b0; brValid = 1'b1;
    brPc = 32'h0000_1234; useMem = 1'b0; fixedWin = 48'h0009_0009_0009;
    step(); step();
    check32("rst_addr", icPcAddr, 32'hA000_0000);
    check32("rst_valid", {31'h0, idOpValid}, 32'h0);
    check32("rst_word", idOpWord, 32'h0);
    check32("rst_oppc", idOpPc, 32'h0);
    check32("rst_len", {31'h0, idOpLen}, 32'h0);
    check32("rst_fault", {31'h0, ifFault}, 32'h0);
    check32("rst_faultpc", ifFaultPc, 32'h0);
    reset = 1'b0; brValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check32("seq_valid", {31'h0, idOpValid}, 32'h1);
      check32("seq_oppc", idOpPc, 32'hA000_0000 + 32'(2 * i));
      check32("seq_len", {31'h0, idOpLen}, 32'h0);
      check32("seq_word", idOpWord, 32'h0000_0009);
    end

    // Length vectors starting at 0x100.
    brValid = 1'b1; brPc = 32'h0000_0100; icPcOK = UMEM_OK_READY;
    step();
    brValid = 1'b0;
    check32("br100_addr", icPcAddr, 32'h0000_0100);
    check32("br100_valid", {31'h0, idOpValid}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      fixedWin = tbl[i].win; icPcOK = UMEM_OK_OK; a = icPcAddr;
      step();
      check32("tbl_word", idOpWord, tbl[i].expWord);
      check32("tbl_len", {31'h0, idOpLen}, {31'h0, tbl[i].expLen});
      check32("tbl_oppc", idOpPc, a);
      check32("tbl_next", icPcAddr, a + (tbl[i].expLen ? 32'd4 : 32'd2));
    end

    // Miss: READY for 3 cycles then OK.
    fixedWin = 48'h0009_0009_0009; icPcOK = UMEM_OK_READY; a = icPcAddr;
    for (int i = 0; i < 3; i++) begin
      step();
      check32("miss_addr", icPcAddr, a);
      check32("miss_valid", {31'h0, idOpValid}, 32'h0);
    end
    check32("miss_state", {30'h0, dbgState}, {30'h0, ST_WAIT});
    icPcOK = UMEM_OK_OK;
    check32("miss_addr4", icPcAddr, a);
    step();
    check32("miss_op", idOpPc, a);
    check32("miss_opv", {31'h0, idOpValid}, 32'h1);
    icPcOK = UMEM_OK_READY;
    step();
    check32("miss_nodup", {31'h0, idOpValid}, 32'h0);

    // Decode stall for 2 cycles.
    icPcOK = UMEM_OK_OK;
    step();
    p = idOpPc; w = idOpWord; a = icPcAddr; idStall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check32("stall_oppc", idOpPc, p);
      check32("stall_word", idOpWord, w);
      check32("stall_addr", icPcAddr, a);
      check32("stall_valid", {31'h0, idOpValid}, 32'h1);
    end
    idStall = 1'b0;
    step();
    check32("stall_next", idOpPc, a);

    // Redirect during stall flushes the op.
    idStall = 1'b1; brValid = 1'b1; brPc = 32'h0000_2001;
    step();
    check32("brst_valid", {31'h0, idOpValid}, 32'h0);
    check32("brst_addr", icPcAddr, 32'h0000_2000);
    brValid = 1'b0; idStall = 1'b0;
    step();
    check32("brst_op", idOpPc, 32'h0000_2000);
    check32("brst_opv", {31'h0, idOpValid}, 32'h1);

    // Fault at 0x300, recovered by redirect to 0x400.
    brValid = 1'b1; brPc = 32'h0000_0300; icPcOK = UMEM_OK_READY;
    step();
    brValid = 1'b0; icPcOK = UMEM_OK_FAULT;
    step();
    check32("flt_set", {31'h0, ifFault}, 32'h1);
    check32("flt_pc", ifFaultPc, 32'h0000_0300);
    check32("flt_valid", {31'h0, idOpValid}, 32'h0);
    icPcOK = UMEM_OK_OK;
    step(); step();
    check32("flt_hold", {31'h0, ifFault}, 32'h1);
    check32("flt_noop", {31'h0, idOpValid}, 32'h0);
    check32("flt_addr", icPcAddr, 32'h0000_0300);
    brValid = 1'b1; brPc = 32'h0000_0400;
    step();
    check32("flt_clr", {31'h0, ifFault}, 32'h0);
    check32("flt_braddr", icPcAddr, 32'h0000_0400);
    brValid = 1'b0;
    step();
    check32("flt_resume", idOpPc, 32'h0000_0400);
    check32("flt_resv", {31'h0, idOpValid}, 32'h1);

    // PC wrap for 16-bit and 32-bit ops.
    brValid = 1'b1; brPc = 32'hFFFF_FFFE;
    step();
    brValid = 1'b0;
    step();
    check32("wrap16_op", idOpPc, 32'hFFFF_FFFE);
    check32("wrap16_addr", icPcAddr, 32'h0);
    brValid = 1'b1; brPc = 32'hFFFF_FFFC; fixedWin = 48'h0000_5678_8A00;
    step();
    brValid = 1'b0;
    step();
    check32("wrap32_len", {31'h0, idOpLen}, 32'h1);
    check32("wrap32_addr", icPcAddr, 32'h0);

    // Random run: every transferred op must follow the program image from the last redirect.
    useMem = 1'b1; live = 1'b0; expPc = 32'h0; transfers = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      brValid = (cyc == 0) || ($urandom_range(0, 99) < 3);
      brPc = $urandom;
      r = $urandom_range(0, 99);
      icPcOK = (r < 70) ? UMEM_OK_OK : (r < 85) ? UMEM_OK_READY : UMEM_OK_HOLD;
      idStall = ($urandom_range(0, 99) < 30);
      #0;
      preValid = idOpValid; preStall = idStall; preBr = brValid; preBrPc = brPc;
      preOk = icPcOK; preAddr = icPcAddr; preOpPc = idOpPc; preWord = idOpWord; preLen = idOpLen;
      step();
      if (live && preValid && !preStall) begin
        w0 = memw(expPc); w1 = memw(expPc + 32'd2);
        expLen = (w0[15:8] == 8'h8A) || (w0[15:8] == 8'h8E);
        expWord = expLen ? {w1, w0} : {16'h0000, w0};
        check32("rnd_pc", preOpPc, expPc);
        check32("rnd_word", preWord, expWord);
        check32("rnd_len", {31'h0, preLen}, {31'h0, expLen});
        expPc = expPc + (expLen ? 32'd4 : 32'd2);
        transfers++;
      end
      if (preBr) begin
        live = 1'b1;
        expPc = {preBrPc[31:1], 1'b0};
      end else if (preOk != UMEM_OK_OK) begin
        check32("rnd_missaddr", icPcAddr, preAddr);
      end
    end
    check32("rnd_progress", {31'h0, transfers >= 300}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
